// File: rtl/hazard_ctrl_pkg.sv
// Shared stall-bus definitions for the hazard controller.
// Bit order of the bus runs from PC (bit 0) up to WB (bit 5).
package hazard_ctrl_pkg;

  localparam int STALL_W = 6;

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int ST_PC  = 0;
  localparam int ST_IF  = 1;
  localparam int ST_ID  = 2;
  localparam int ST_EX  = 3;
  localparam int ST_MEM = 4;
  localparam int ST_WB  = 5;

  localparam stall_bus_t STALL_NONE     = 6'b000000;
  localparam stall_bus_t STALL_LOAD_USE = 6'b000111;
  localparam stall_bus_t STALL_DIV      = 6'b001111;

  typedef struct packed {
    logic       is_load;
    logic       rf_we;
    logic [4:0] waddr;
  } ex_wr_t;

  // True when the ID instruction reads a register the EX load is writing.
  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic load_use_hit(
    input ex_wr_t     ex,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    logic rs_hit;
    logic rt_hit;
    rs_hit = use_rs && (rs == ex.waddr);
    rt_hit = use_rt && (rt == ex.waddr);
    return ex.is_load && ex.rf_we
        && (ex.waddr != 5'd0)
        && (rs_hit || rt_hit);
  endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles and multi-cycle divide stalls.
// Divide sequencing is present only when HAZARD_CTRL_DIV_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_is_load,
  input  logic       ex_rf_we,
  input  logic [4:0] ex_rf_waddr,
  input  logic       div_start,
  output stall_bus_t stall,
  output logic       div_done,
  output logic       div_busy
);

  if (DIV_CYCLES < 1) begin : g_bad_div_cycles
    $error("hazard_ctrl: DIV_CYCLES must be at least 1");
  end

  ex_wr_t ex;
  logic   load_use;

  // Combinational load-use detect so ID bubbles in the same cycle.
  always_comb begin
    ex = '{
      is_load: ex_is_load,
      rf_we:   ex_rf_we,
      waddr:   ex_rf_waddr
    };
    load_use = load_use_hit(
      ex, id_rs, id_rt, id_use_rs, id_use_rt
    );
  end

`ifdef HAZARD_CTRL_DIV_EN

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } state_t;

  localparam int CW =
    (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(DIV_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          busy_q;
  logic          busy_nxt;

  // State, counter and busy flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Next state: a start in IDLE arms the counter; busy ignores new starts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (div_start) begin
          state_nxt = DIV_BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      DIV_BUSY: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt == DIV_BUSY);
  end

  // Outputs: divide stall covers the load-use stall, reset forces quiet.
  always_comb begin
    stall    = STALL_NONE;
    div_done = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (load_use) begin
            stall = STALL_LOAD_USE;
          end
        end
        DIV_BUSY: begin
          stall    = STALL_DIV;
          div_done = (cnt == '0);
        end
        default: begin
          stall = STALL_NONE;
        end
      endcase
    end
  end

  assign div_busy = busy_q;

`else

  logic unused_div;
  assign unused_div = ^{clk, div_start};

  // Load-use is the only stall source without the divider.
  always_comb begin
    stall = STALL_NONE;
    if (!rst && load_use) begin
      stall = STALL_LOAD_USE;
    end
  end

  assign div_done = 1'b0;
  assign div_busy = 1'b0;

`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a remaining-cycles model.
// Expectations follow HAZARD_CTRL_DIV_EN the same way the build does.
module tb_hazard_ctrl;

  localparam int DIVN = 32;
`ifdef HAZARD_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       ex_is_load;
  logic       ex_rf_we;
  logic [4:0] ex_rf_waddr;
  logic       div_start;
  logic [5:0] stall;
  logic       div_done;
  logic       div_busy;

  int errors = 0;
  int checks = 0;
  int rem    = 0;
  int stall_div_cycles = 0;
  int done_count = 0;

  hazard_ctrl #(.DIV_CYCLES(DIVN)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_is_load  (ex_is_load),
    .ex_rf_we    (ex_rf_we),
    .ex_rf_waddr (ex_rf_waddr),
    .div_start   (div_start),
    .stall       (stall),
    .div_done    (div_done),
    .div_busy    (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [5:0] got,
    input logic [5:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance.
  task automatic step(
    input string      tag,
    input logic       r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       urs,
    input logic       urt,
    input logic       ld,
    input logic       we,
    input logic [4:0] wa,
    input logic       ds
  );
    logic       lu;
    logic [5:0] exp_stall;
    logic       exp_done;
    logic       exp_busy;
    rst = r;
    id_rs = rs;
    id_rt = rt;
    id_use_rs = urs;
    id_use_rt = urt;
    ex_is_load = ld;
    ex_rf_we = we;
    ex_rf_waddr = wa;
    div_start = ds;
    #2;
    lu = ld && we && (wa != 0)
      && ((urs && rs == wa) || (urt && rt == wa));
    if (r) exp_stall = 6'b000000;
    else if (rem > 0) exp_stall = 6'b001111;
    else if (lu) exp_stall = 6'b000111;
    else exp_stall = 6'b000000;
    exp_done = !r && (rem == 1);
    exp_busy = (rem > 0);
    chk({tag, ".stall"}, stall, exp_stall);
    chk({tag, ".done"}, {5'd0, div_done},
        {5'd0, exp_done});
    chk({tag, ".busy"}, {5'd0, div_busy},
        {5'd0, exp_busy});
    if (stall === 6'b001111) stall_div_cycles++;
    if (div_done === 1'b1) done_count++;
    @(posedge clk);
    if (r) rem = 0;
    else if (rem > 0) rem = rem - 1;
    else if (ds && DIV_EN) rem = DIVN;
    #1;
  endtask

  task automatic idle(input string tag, input logic ds);
    step(tag, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0,
         1'b0, 1'b0, 5'd0, ds);
  endtask

  initial begin
    rst = 1'b1;
    id_rs = '0;
    id_rt = '0;
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    ex_is_load = 1'b0;
    ex_rf_we = 1'b0;
    ex_rf_waddr = '0;
    div_start = 1'b0;
    @(posedge clk);
    #1;

    step("rst_hazard", 1'b1, 5'd3, 5'd3, 1'b1, 1'b1,
         1'b1, 1'b1, 5'd3, 1'b1);
    step("rst_quiet", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0,
         1'b0, 1'b0, 5'd0, 1'b0);

    step("lu_rs8", 1'b0, 5'd8, 5'd1, 1'b1, 1'b0,
         1'b1, 1'b1, 5'd8, 1'b0);
    step("lu_r0", 1'b0, 5'd0, 5'd1, 1'b1, 1'b0,
         1'b1, 1'b1, 5'd0, 1'b0);
    step("lu_rt9_unused", 1'b0, 5'd1, 5'd9, 1'b0, 1'b0,
         1'b1, 1'b1, 5'd9, 1'b0);
    step("lu_rt9_used", 1'b0, 5'd1, 5'd9, 1'b0, 1'b1,
         1'b1, 1'b1, 5'd9, 1'b0);
    step("lu_no_we", 1'b0, 5'd8, 5'd1, 1'b1, 1'b0,
         1'b1, 1'b0, 5'd8, 1'b0);
    step("lu_not_load", 1'b0, 5'd8, 5'd1, 1'b1, 1'b0,
         1'b0, 1'b1, 5'd8, 1'b0);

    stall_div_cycles = 0;
    done_count = 0;
    idle("div_start", 1'b1);
    for (int i = 0; i < DIVN + 3; i++) idle("div_run", 1'b0);
    chk("div_len", 6'(stall_div_cycles),
        DIV_EN ? 6'(DIVN) : 6'd0);
    chk("div_done_cnt", 6'(done_count),
        DIV_EN ? 6'd1 : 6'd0);

    done_count = 0;
    idle("abort_start", 1'b1);
    for (int i = 1; i < 10; i++) idle("abort_run", 1'b0);
    step("abort_rst", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0,
         1'b0, 1'b0, 5'd0, 1'b0);
    idle("abort_after", 1'b0);
    for (int i = 0; i < DIVN; i++) idle("abort_tail", 1'b0);
    chk("abort_no_done", 6'(done_count), 6'd0);

    stall_div_cycles = 0;
    done_count = 0;
    idle("redo_start", 1'b1);
    for (int i = 1; i <= DIVN + 3; i++) begin
      if (i == 5)
        step("redo_restart_lu", 1'b0, 5'd7, 5'd1, 1'b1, 1'b0,
             1'b1, 1'b1, 5'd7, 1'b1);
      else if (i == 12)
        step("redo_lu", 1'b0, 5'd1, 5'd4, 1'b0, 1'b1,
             1'b1, 1'b1, 5'd4, 1'b0);
      else
        idle("redo_run", 1'b0);
    end
    chk("redo_len", 6'(stall_div_cycles),
        DIV_EN ? 6'(DIVN) : 6'd0);
    chk("redo_done_cnt", 6'(done_count),
        DIV_EN ? 6'd1 : 6'd0);

    step("start_with_lu", 1'b0, 5'd5, 5'd1, 1'b1, 1'b0,
         1'b1, 1'b1, 5'd5, 1'b1);
    for (int i = 0; i < DIVN + 2; i++) idle("swl_run", 1'b0);

    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 49) == 0),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_CYCLES, default 32, meaning EX-stage stall cycles per divide operation.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port id_rs, input, 5, ID-stage source register 1 address.
REQ-005 The block SHALL have port id_rt, input, 5, ID-stage source register 2 address.
REQ-006 The block SHALL have port id_use_rs, input, 1, ID instruction reads rs.
REQ-007 The block SHALL have port id_use_rt, input, 1, ID instruction reads rt.
REQ-008 The block SHALL have port ex_is_load, input, 1, EX-stage instruction is a load.
REQ-009 The block SHALL have port ex_rf_we, input, 1, EX-stage register write enable.
REQ-010 The block SHALL have port ex_rf_waddr, input, 5, EX-stage destination register.
REQ-011 The block SHALL have port div_start, input, 1, EX-stage divide issue pulse.
REQ-012 The block SHALL have port stall, output, StallBus (6), per-stage stop: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; Stop=1.
REQ-013 The block SHALL have port div_done, output, 1, one-cycle pulse in the last divide stall cycle.
REQ-014 The block SHALL have port div_busy, output, 1, registered; high while the divide sequence runs.

Function
REQ-015 Load-use hazard SHALL be ex_is_load & ex_rf_we & ex_rf_waddr!=0 & ((id_use_rs & id_rs==ex_rf_waddr) | (id_use_rt & id_rt==ex_rf_waddr)).
REQ-016 A load-use hazard SHALL drive stall=6'b000111 combinationally in the same cycle, so ID takes a bubble while EX advances.
REQ-017 Register 0 SHALL never cause a hazard.
REQ-018 The FSM SHALL have two states: IDLE and DIV_BUSY.
REQ-019 IDLE->DIV_BUSY SHALL occur on a rising edge with div_start=1; the cycle counter SHALL load DIV_CYCLES-1.
REQ-020 In DIV_BUSY, stall SHALL be 6'b001111 and the counter SHALL decrement each cycle.
REQ-021 In DIV_BUSY with counter==0, div_done SHALL be 1 for that cycle only, and the FSM SHALL return to IDLE at the next edge.
REQ-022 The total divide stall SHALL therefore be exactly DIV_CYCLES cycles starting the cycle after div_start.
REQ-023 div_start received while in DIV_BUSY SHALL be ignored.
REQ-024 In DIV_BUSY, a simultaneous load-use hazard SHALL be absorbed: stall SHALL remain 6'b001111, which is a superset of the load-use stall.
REQ-025 In IDLE with no hazard, stall SHALL be 6'b000000.
REQ-026 div_start together with a load-use hazard in the same IDLE cycle SHALL produce stall=6'b000111 that cycle and enter DIV_BUSY next.
REQ-027 A DIV_CYCLES value below 1 SHALL be rejected at elaboration.

Reset
REQ-028 During rst, state SHALL be IDLE, the counter 0, div_busy 0, div_done 0, and stall 6'b000000 regardless of other inputs.
REQ-029 rst asserted mid-divide SHALL abort the sequence at the next edge, with no div_done.

Configuration
REQ-030 Macro HAZARD_CTRL_DIV_EN defined: the DIV_BUSY state, counter, div_busy and div_done SHALL be present as specified.
REQ-031 Macro HAZARD_CTRL_DIV_EN undefined: div_start SHALL be ignored, div_busy and div_done SHALL be tied 0, and only load-use stalls SHALL be generated.

Structure
REQ-032 StallBus, Stop/NoStop and the stall patterns STALL_LOAD_USE=6'b000111 and STALL_DIV=6'b001111 SHALL live in the shared defines header.
REQ-033 The FSM state encoding SHALL be local to the module.
REQ-034 The design SHALL be a single module with no sub-modules.

Verification
REQ-035 A bench SHALL check: ex_is_load=1, ex_rf_we=1, ex_rf_waddr=8, id_rs=8, id_use_rs=1 -> stall=000111 in the same cycle.
REQ-036 A bench SHALL check: the same stimulus with ex_rf_waddr=0 and id_rs=0 -> stall=000000.
REQ-037 A bench SHALL check: ex_rf_waddr=9, id_rt=9, id_use_rt=0 -> stall=000000.
REQ-038 A bench SHALL check: with DIV_CYCLES=32, a div_start pulse -> stall=001111 for exactly 32 cycles, div_done high only on the 32nd, then stall=000000.
REQ-039 A bench SHALL check: rst asserted at divide cycle 10 -> the next cycle has stall=000000, div_busy=0, and no div_done.
REQ-040 A bench SHALL check: a second div_start and a load-use hazard during DIV_BUSY -> the divide length is unchanged at 32 cycles and stall stays 001111.
